// File: rtl/noc_traffic_pkg.sv
// Shared NoC traffic types and widths used by the generators and the injection arbiter.
package noc_traffic_pkg;

  localparam int unsigned PACKET_WIDTH    = 32;
  localparam int unsigned DEF_NODE_COUNT  = 16;
  localparam int unsigned DEF_DEST_WIDTH  = $clog2(DEF_NODE_COUNT);
  localparam int unsigned DEF_ID_WIDTH    = 8;

  typedef struct packed {
    logic [PACKET_WIDTH-1:0]   data;
    logic [DEF_DEST_WIDTH-1:0] dest;
    logic [DEF_ID_WIDTH-1:0]   id;
  } traffic_pkt_t;

  // Single-step modulo wrap for round-robin index arithmetic (idx < 2*n).
  function automatic int unsigned rr_wrap(input int unsigned idx, input int unsigned n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/traffic_src_fifo.sv
// Per-source synchronous FIFO; full/empty are decoded from the pre-edge count.
module traffic_src_fifo #(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned WIDTH = 44,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata_c,
  output logic             full_c,
  output logic             empty_c,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok_c;
  logic             pop_ok_c;

  assign full_c    = (count == CW'(DEPTH));
  assign empty_c   = (count == '0);
  assign push_ok_c = push & ~full_c;
  assign pop_ok_c  = pop & ~empty_c;
  assign rdata_c   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok_c) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok_c) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok_c)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_ok_c) - CW'(pop_ok_c);
    end
  end

endmodule

// File: rtl/traffic_injection_arbiter.sv
// Buffers per-source traffic strobes and injects them round-robin into one NoC port.
module traffic_injection_arbiter
  import noc_traffic_pkg::*;
#(
  parameter  int unsigned NUM_SRC         = 4,
  parameter  int unsigned NODE_COUNT      = 16,
  parameter  int unsigned PACKET_ID_WIDTH = 8,
  parameter  int unsigned FIFO_DEPTH      = 4,
  parameter  int unsigned DROP_CNT_WIDTH  = 16,
  localparam int unsigned DW              = $clog2(NODE_COUNT),
  localparam int unsigned IW              = PACKET_ID_WIDTH,
  localparam int unsigned SW              = $clog2(NUM_SRC)
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [NUM_SRC-1:0]                      src_valid,
  input  logic [NUM_SRC-1:0][PACKET_WIDTH-1:0]    src_packet,
  input  logic [NUM_SRC-1:0][DW-1:0]              src_dest,
  input  logic [NUM_SRC-1:0][IW-1:0]              src_id,
  output logic [NUM_SRC-1:0]                      src_busy,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [PACKET_WIDTH-1:0]                 out_packet,
  output logic [DW-1:0]                           out_dest,
  output logic [IW-1:0]                           out_id,
  output logic [SW-1:0]                           out_src,
  input  logic                                    clear_drops,
  output logic [NUM_SRC-1:0][DROP_CNT_WIDTH-1:0]  drop_count
);

  localparam int unsigned PW = PACKET_WIDTH + DW + IW;
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] BUSY_LEVEL = CW'(FIFO_DEPTH - 1);

  logic [NUM_SRC-1:0]          push_c;
  logic [NUM_SRC-1:0]          pop_c;
  logic [NUM_SRC-1:0]          full_c;
  logic [NUM_SRC-1:0]          empty_c;
  logic [NUM_SRC-1:0]          busy_d_c;
  logic [NUM_SRC-1:0][PW-1:0]  rdata_c;
  logic [NUM_SRC-1:0][CW-1:0]  count;
  logic [SW-1:0]               rr_ptr;
  logic [SW-1:0]               gnt_idx_c;
  logic                        gnt_found_c;
  logic                        free_c;
  int unsigned                 scan_idx;

  assign free_c = ~out_valid | out_ready;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign push_c[i] = src_valid[i] & ~full_c[i];
    assign pop_c[i]  = free_c & gnt_found_c & (gnt_idx_c == SW'(i));

    traffic_src_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (PW)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push_c[i]),
      .pop     (pop_c[i]),
      .wdata   ({src_packet[i], src_dest[i], src_id[i]}),
      .rdata_c (rdata_c[i]),
      .full_c  (full_c[i]),
      .empty_c (empty_c[i]),
      .count   (count[i])
    );
  end

  // First non-empty FIFO at or after rr_ptr, wrapping.
  always_comb begin
    gnt_found_c = 1'b0;
    gnt_idx_c   = '0;
    scan_idx    = 0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      scan_idx = rr_wrap(32'(rr_ptr) + k, NUM_SRC);
      if (!gnt_found_c && !empty_c[SW'(scan_idx)]) begin
        gnt_found_c = 1'b1;
        gnt_idx_c   = SW'(scan_idx);
      end
    end
  end

  // Busy is registered from the post-edge count so it lines up with the FIFO count.
  always_comb begin
    busy_d_c = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      busy_d_c[i] = (count[i] + CW'(push_c[i]) - CW'(pop_c[i])) >= BUSY_LEVEL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_busy   <= '0;
      drop_count <= '0;
    end else begin
      src_busy <= busy_d_c;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (clear_drops) begin
          drop_count[i] <= '0;
        end else if (src_valid[i] && full_c[i] && (drop_count[i] != '1)) begin
          drop_count[i] <= drop_count[i] + DROP_CNT_WIDTH'(1);
        end
      end
    end
  end

  // Output register: reload whenever empty or being consumed this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_packet <= '0;
      out_dest   <= '0;
      out_id     <= '0;
      out_src    <= '0;
      rr_ptr     <= '0;
    end else if (free_c) begin
      if (gnt_found_c) begin
        out_valid                        <= 1'b1;
        {out_packet, out_dest, out_id}   <= rdata_c[gnt_idx_c];
        out_src                          <= gnt_idx_c;
        rr_ptr                           <= SW'(rr_wrap(32'(gnt_idx_c) + 1, NUM_SRC));
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_traffic_injection_arbiter.sv
// Directed self-checking bench for traffic_injection_arbiter (4 sources, depth 4, 4-bit drop counters).
module tb_traffic_injection_arbiter;

  localparam int unsigned NS = 4;
  localparam int unsigned DW = 4;
  localparam int unsigned IW = 8;
  localparam int unsigned DCW = 4;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NS-1:0]           src_valid;
  logic [NS-1:0][31:0]     src_packet;
  logic [NS-1:0][DW-1:0]   src_dest;
  logic [NS-1:0][IW-1:0]   src_id;
  logic [NS-1:0]           src_busy;
  logic                    out_valid;
  logic                    out_ready;
  logic [31:0]             out_packet;
  logic [DW-1:0]           out_dest;
  logic [IW-1:0]           out_id;
  logic [1:0]              out_src;
  logic                    clear_drops;
  logic [NS-1:0][DCW-1:0]  drop_count;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  traffic_injection_arbiter #(
    .NUM_SRC         (NS),
    .NODE_COUNT      (16),
    .PACKET_ID_WIDTH (IW),
    .FIFO_DEPTH      (4),
    .DROP_CNT_WIDTH  (DCW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .src_valid   (src_valid),
    .src_packet  (src_packet),
    .src_dest    (src_dest),
    .src_id      (src_id),
    .src_busy    (src_busy),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_packet  (out_packet),
    .out_dest    (out_dest),
    .out_id      (out_id),
    .out_src     (out_src),
    .clear_drops (clear_drops),
    .drop_count  (drop_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    rst_n       = 1'b0;
    src_valid   = '0;
    src_packet  = '0;
    src_dest    = '0;
    src_id      = '0;
    out_ready   = 1'b1;
    clear_drops = 1'b0;
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_packet", 64'(out_packet), 64'd0);
    chk("rst_out_src", 64'(out_src), 64'd0);
    chk("rst_busy", 64'(src_busy), 64'd0);
    chk("rst_drops", 64'(drop_count), 64'd0);
    step();
    step();
    rst_n = 1'b1;

    // Round robin: all four sources at once, grants 0..3 back to back.
    for (int i = 0; i < 4; i++) begin
      src_packet[i] = 32'hA000_0000 + 32'(i);
      src_dest[i]   = 4'(8 + i);
      src_id[i]     = 8'(16 + i);
    end
    src_valid = 4'hF;
    step();
    src_valid = '0;
    chk("rr_lat_cycle1", 64'(out_valid), 64'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rr_valid", 64'(out_valid), 64'd1);
      chk("rr_src", 64'(out_src), 64'(k));
      chk("rr_id", 64'(out_id), 64'(16 + k));
      chk("rr_packet", 64'(out_packet), 64'(32'hA000_0000 + 32'(k)));
      chk("rr_dest", 64'(out_dest), 64'(8 + k));
    end
    step();
    chk("rr_idle", 64'(out_valid), 64'd0);

    // Second burst starts again at source 0.
    for (int i = 0; i < 4; i++) src_id[i] = 8'(32 + i);
    src_valid = 4'hF;
    step();
    src_valid = '0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rr2_src", 64'(out_src), 64'(k));
      chk("rr2_id", 64'(out_id), 64'(32 + k));
    end
    step();
    chk("rr2_idle", 64'(out_valid), 64'd0);

    // Single push into idle arbiter: two-cycle latency, one-cycle presence.
    src_packet[2] = 32'hDEAD_BEEF;
    src_dest[2]   = 4'd5;
    src_id[2]     = 8'd1;
    src_valid     = 4'b0100;
    step();
    src_valid = '0;
    chk("single_cycle1", 64'(out_valid), 64'd0);
    step();
    chk("single_valid", 64'(out_valid), 64'd1);
    chk("single_packet", 64'(out_packet), 64'hDEAD_BEEF);
    chk("single_dest", 64'(out_dest), 64'd5);
    chk("single_id", 64'(out_id), 64'd1);
    chk("single_src", 64'(out_src), 64'd2);
    step();
    chk("single_gone", 64'(out_valid), 64'd0);

    // Backpressure: rr_ptr is 3, so source 0 wins over source 1.
    out_ready = 1'b0;
    src_id[0] = 8'h30;
    src_id[1] = 8'h31;
    src_valid = 4'b0011;
    step();
    src_valid = '0;
    step();
    chk("bp_valid", 64'(out_valid), 64'd1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk("bp_hold_src", 64'(out_src), 64'd0);
      chk("bp_hold_id", 64'(out_id), 64'h30);
      chk("bp_hold_packet", 64'(out_packet), 64'hA000_0000);
    end
    out_ready = 1'b1;
    step();
    chk("bp_next_src", 64'(out_src), 64'd1);
    chk("bp_next_id", 64'(out_id), 64'h31);
    step();
    chk("bp_drained", 64'(out_valid), 64'd0);

    // Overflow on source 1 with the port stalled.
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      src_id[1] = 8'(64 + k);
      src_valid = 4'b0010;
      step();
      chk("ovf_busy", 64'(src_busy[1]), 64'((k >= 3) ? 1 : 0));
      chk("ovf_drop", 64'(drop_count[1]), 64'((k == 5) ? 1 : 0));
    end
    src_valid = '0;
    chk("ovf_out_id", 64'(out_id), 64'h40);
    chk("ovf_out_src", 64'(out_src), 64'd1);
    src_id[1] = 8'h46;
    src_valid = 4'b0010;
    step();
    src_valid = '0;
    chk("ovf_drop2", 64'(drop_count[1]), 64'd2);
    src_valid   = 4'b0010;
    clear_drops = 1'b1;
    step();
    src_valid   = '0;
    clear_drops = 1'b0;
    chk("clear_wins", 64'(drop_count[1]), 64'd0);

    // Saturation of the 4-bit counter.
    for (int k = 0; k < 20; k++) begin
      src_valid = 4'b0010;
      step();
      if (k == 14) chk("sat_at15", 64'(drop_count[1]), 64'd15);
    end
    src_valid = '0;
    chk("sat_hold", 64'(drop_count[1]), 64'd15);
    chk("sat_other", 64'(drop_count[0]), 64'd0);

    // Drain: no loss, no duplication.
    chk("drain_head", 64'(out_id), 64'h40);
    out_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      step();
      chk("drain_id", 64'(out_id), 64'(64 + k));
      chk("drain_src", 64'(out_src), 64'd1);
    end
    step();
    chk("drain_empty", 64'(out_valid), 64'd0);
    chk("drain_busy", 64'(src_busy), 64'd0);

    // Reset mid-traffic, rr_ptr is 2 so source 2 is presented first.
    out_ready = 1'b0;
    src_id[0] = 8'h50;
    src_id[1] = 8'h51;
    src_id[2] = 8'h52;
    src_valid = 4'b0111;
    step();
    src_valid = '0;
    step();
    chk("pre_rst_src", 64'(out_src), 64'd2);
    chk("pre_rst_id", 64'(out_id), 64'h52);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", 64'(out_valid), 64'd0);
    chk("mrst_src", 64'(out_src), 64'd0);
    chk("mrst_packet", 64'(out_packet), 64'd0);
    chk("mrst_id", 64'(out_id), 64'd0);
    chk("mrst_drops", 64'(drop_count), 64'd0);
    chk("mrst_busy", 64'(src_busy), 64'd0);
    step();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    step();
    chk("post_rst_idle1", 64'(out_valid), 64'd0);
    step();
    chk("post_rst_idle2", 64'(out_valid), 64'd0);
    src_id[3] = 8'h55;
    src_valid = 4'b1000;
    step();
    src_valid = '0;
    chk("post_rst_lat1", 64'(out_valid), 64'd0);
    step();
    chk("post_rst_valid", 64'(out_valid), 64'd1);
    chk("post_rst_src", 64'(out_src), 64'd3);
    chk("post_rst_id", 64'(out_id), 64'h55);
    step();
    chk("post_rst_gone", 64'(out_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/traffic_injection_arbiter.md
# traffic_injection_arbiter

Shares one NoC injection port among NUM_SRC traffic generators. The generators emit single-cycle `valid` pulses and have no backpressure of their own. The block buffers each source in a small FIFO and grants the port round-robin over a registered valid/ready output. It also returns a per-source `busy` throttle to generators that honour it, and counts packets dropped on FIFO overflow. It sits between the per-node generator bank and the router local input.

## Interface
- NUM_SRC, 4: number of generator sources; ≥2
- NODE_COUNT, 16: NoC node count; sets destination width DW = $clog2(NODE_COUNT)
- PACKET_ID_WIDTH, 8: packet id width (IW)
- FIFO_DEPTH, 4: entries per source FIFO; power of two, ≥2
- DROP_CNT_WIDTH, 16: width of each saturating drop counter

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- src_valid  in  [NUM_SRC]  one-cycle packet strobe per source
- src_packet  in  [NUM_SRC][32]  payload
- src_dest  in  [NUM_SRC][DW]  destination node
- src_id  in  [NUM_SRC][IW]  packet id
- src_busy  out  [NUM_SRC]  throttle to source i; high when its FIFO count ≥ FIFO_DEPTH-1
- out_valid  out  1  injection request
- out_ready  in  1  router accepts the packet
- out_packet  out  32  granted payload
- out_dest  out  DW  granted destination
- out_id  out  IW  granted id
- out_src  out  $clog2(NUM_SRC)  index of the granted source
- clear_drops  in  1  synchronous clear of all drop counters
- drop_count  out  [NUM_SRC][DROP_CNT_WIDTH]  packets dropped per source

## Operation
- **Push.** When src_valid[i]=1 and FIFO i is not full, {packet, dest, id} is written to FIFO i.
- **Overflow.** When src_valid[i]=1 and FIFO i is full, the packet is dropped and drop_count[i] increments.
- **Full is pre-edge.** "Full" is the count before the clock edge. A push to a full FIFO is dropped even if a pop happens in the same cycle.
- **Drop counters.** They saturate at all-ones. clear_drops wins over a simultaneous increment, so the counter reads 0.
- **Output register.** It holds one packet. It is "free" when out_valid=0, or when out_valid=1 and out_ready=1 (consumed this cycle).
- **Arbitration.** When the output register is free, the arbiter scans non-empty FIFOs starting at rr_ptr, wrapping modulo NUM_SRC. It pops the first one, loads the register and sets out_src.
  - rr_ptr then becomes (granted+1) mod NUM_SRC.
  - If no FIFO is non-empty, out_valid clears and rr_ptr is unchanged.
- **Handshake.** While out_valid=1 and out_ready=0, out_packet, out_dest, out_id and out_src hold stable and no FIFO is popped.
- **Full throughput.** One packet per cycle is sustained when out_ready is held high.
- **Throttle.** src_busy[i] is decoded from the registered count and carries no combinational path from inputs.
- **Reset.** Asynchronous, and applies mid-operation too.
  - All FIFOs empty; buffered and in-flight packets are discarded.
  - rr_ptr=0, all drop_count=0, all src_busy=0.
  - out_valid=0; out_packet, out_dest, out_id and out_src all 0.

## Timing
- src_valid high in cycle 0 → FIFO count=1 in cycle 1 → out_valid=1 in cycle 2. Minimum latency is 2 cycles into an idle arbiter.
- out_valid & out_ready in cycle n → the next packet, if one is buffered, is presented in cycle n+1 with no bubble.
- src_busy[i] rises in the cycle after the push that brings the count to FIFO_DEPTH-1.
- drop_count updates in the cycle after the dropped strobe.

## Structure
- Package `noc_traffic_pkg`:
  - PACKET_WIDTH=32.
  - Typedef `traffic_pkt_t` = {data[31:0], dest, id}, parameterised via localparam widths shared with the generators.
- Sub-module `traffic_src_fifo`, instantiated NUM_SRC times:
  - Synchronous FIFO with push, pop, full, empty and count.
  - Pointer width $clog2(FIFO_DEPTH); count width is one bit wider.
- Round-robin select, output register and drop counters stay in the top module.

## Test plan
- **Single push, idle.** src_valid[2] pulse with packet 0xDEADBEEF, dest 5, id 1; out_ready=1 → out_valid in cycle 2 with 0xDEADBEEF/5/1 and out_src=2, held for exactly one cycle.
- **Round robin.** All 4 sources pulse together in the same cycle; out_ready=1 → grants 0,1,2,3 on consecutive cycles. A second burst then grants starting at 0 again (rr_ptr wraps from 3 to 0).
- **Backpressure.** out_ready=0 for 5 cycles with out_valid=1 → payload and out_src stable and FIFO counts unchanged. Release → drain with no lost or duplicated ids.
- **Overflow.** FIFO_DEPTH=4, out_ready=0, 6 pulses on source 1 → 1 packet in the output register, 4 in the FIFO, 1 dropped (drop_count[1]=1, src_busy[1]=1). A further pulse gives drop_count[1]=2; clear_drops gives 0.
- **Saturation.** DROP_CNT_WIDTH=4, 20 drops → drop_count stays at 15.
- **Reset mid-traffic.** rst_n low asynchronously with 3 packets buffered → out_valid=0 immediately, all counts and counters 0. After release, the first packet injected after reset emerges 2 cycles after its src_valid strobe.
